// File: rtl/i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_ctrl
// Brief    : Single-byte open-drain I2C master (START, addr+R/W, ACK, data,
//            ACK/NACK, STOP). Optional clock stretching: I2C_CLK_STRETCH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_ctrl #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  inout  wire        SCL,
  inout  wire        SDA
);

  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_RNACK, S_STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] qcnt;
  logic [1:0]    q;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic [7:0]    wdata_q;
  logic          rw_q;
  logic          nack;
  logic          scl_low;
  logic          sda_low;
  logic [1:0]    sda_sync;
  logic          sda_s;
  logic          tick_raw;
  logic          tick;

  assign SCL      = scl_low ? 1'b0 : 1'bz;
  assign SDA      = sda_low ? 1'b0 : 1'bz;
  assign sda_s    = sda_sync[1];
  assign tick_raw = (qcnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sda_sync <= 2'b11;
    else     sda_sync <= {sda_sync[0], SDA};
  end

`ifdef I2C_CLK_STRETCH_EN
  logic [1:0] scl_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) scl_sync <= 2'b11;
    else     scl_sync <= {scl_sync[0], SCL};
  end

  // Q2 cannot end until the released SCL is actually seen high
  assign tick = tick_raw && ((q != 2'd2) || scl_sync[1]);
`else
  assign tick = tick_raw;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      qcnt    <= '0;
      q       <= 2'd0;
      bitn    <= 3'd0;
      shreg   <= 8'h00;
      wdata_q <= 8'h00;
      rw_q    <= 1'b0;
      nack    <= 1'b0;
      scl_low <= 1'b0;
      sda_low <= 1'b0;
      rdata   <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        qcnt <= '0;
        q    <= 2'd0;
        if (start) begin
          state   <= S_START;
          busy    <= 1'b1;
          ack_err <= 1'b0;
          nack    <= 1'b0;
          shreg   <= {addr, rw};
          rw_q    <= rw;
          wdata_q <= wdata;
          bitn    <= 3'd0;
          scl_low <= 1'b0;
          sda_low <= 1'b0;
        end
      end else if (!tick_raw) begin
        qcnt <= qcnt + CW'(1);
      end else if (tick) begin
        qcnt <= '0;
        q    <= q + 2'd1;
        case (q)
          2'd1: begin
            scl_low <= 1'b0;
            if (state == S_START) sda_low <= 1'b1;
          end
          2'd2: begin
            if ((state == S_AACK || state == S_WACK) && sda_s) nack <= 1'b1;
            if (state == S_RD) shreg <= {shreg[6:0], sda_s};
            if (state == S_STOP) sda_low <= 1'b0;
          end
          2'd3: begin
            scl_low <= 1'b1;
            case (state)
              S_START: begin
                state   <= S_ADDR;
                bitn    <= 3'd0;
                sda_low <= ~shreg[7];
              end
              S_ADDR, S_WR: begin
                if (bitn == 3'd7) begin
                  state   <= (state == S_ADDR) ? S_AACK : S_WACK;
                  sda_low <= 1'b0;
                end else begin
                  bitn    <= bitn + 3'd1;
                  shreg   <= {shreg[6:0], 1'b0};
                  sda_low <= ~shreg[6];
                end
              end
              S_AACK: begin
                bitn <= 3'd0;
                if (nack) begin
                  state   <= S_STOP;
                  sda_low <= 1'b1;
                end else if (rw_q) begin
                  state   <= S_RD;
                  sda_low <= 1'b0;
                end else begin
                  state   <= S_WR;
                  shreg   <= wdata_q;
                  sda_low <= ~wdata_q[7];
                end
              end
              S_WACK: begin
                state   <= S_STOP;
                sda_low <= 1'b1;
              end
              S_RD: begin
                if (bitn == 3'd7) begin
                  state   <= S_RNACK;
                  sda_low <= 1'b0;
                end else begin
                  bitn <= bitn + 3'd1;
                end
              end
              S_RNACK: begin
                state   <= S_STOP;
                sda_low <= 1'b1;
                rdata   <= shreg;
              end
              S_STOP: begin
                state   <= S_IDLE;
                scl_low <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
                ack_err <= nack;
              end
              default: begin
                state   <= S_IDLE;
                scl_low <= 1'b0;
                sda_low <= 1'b0;
                busy    <= 1'b0;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
